// File: rtl/qic117_pkg.sv
// qic117_pkg: shared constants and FSM state type for the QIC-117 STEP counter
package qic117_pkg;
    localparam int QIC_MAX_CMD         = 48;
    localparam int QIC_TIMEOUT_DEFAULT = 5_000_000;
    typedef enum logic [1:0] {IDLE, COUNTING, REPORT} qic_state_t;
endpackage

// File: rtl/qic117_step_filter.sv
// qic117_step_filter: synchronizes raw STEP and emits a one-cycle falling-edge pulse; glitch filter under QIC117_STEP_GLITCH_FILTER_EN
module qic117_step_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic step_n,
    output logic step_edge
);
    logic r_meta;
    logic r_sync;

    // two-flop synchronizer, idles high so STEP reads inactive out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= step_n;
            r_sync <= r_meta;
        end
    end

`ifdef QIC117_STEP_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    logic          r_level;
    logic [CW-1:0] r_run;
    logic          w_diff;
    logic          w_flip;

    assign w_diff    = r_sync != r_level;
    assign w_flip    = w_diff && (r_run == CW'(FILTER_CYCLES - 1));
    assign step_edge = w_flip && r_level;

    // filtered level only follows the input after FILTER_CYCLES matching samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= 1'b1;
            r_run   <= '0;
        end else begin
            r_level <= w_flip ? ~r_level : r_level;
            r_run   <= (w_diff && !w_flip) ? r_run + 1'b1 : '0;
        end
    end
`else
    logic r_prev;

    assign step_edge = r_prev && !r_sync;

    // previous synchronized sample for falling-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_prev <= 1'b1;
        else          r_prev <= r_sync;
    end
`endif
endmodule

// File: rtl/qic117_step_counter.sv
// qic117_step_counter: counts host STEP pulses into a command code, reported after an idle timeout (filter: QIC117_STEP_GLITCH_FILTER_EN)
module qic117_step_counter
    import qic117_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = QIC_TIMEOUT_DEFAULT,
    parameter int FILTER_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       step_n,
    input  logic       enable,
    output logic [5:0] pulse_count,
    output logic       command_valid,
    output logic       cmd_overflow,
    output logic       busy,
    output logic       step_seen
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    qic_state_t r_state;
    qic_state_t w_state_d;
    logic [5:0]    r_count;
    logic [5:0]    w_count_d;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_d;
    logic [5:0]    r_pulse_count;
    logic          r_step_seen;
    logic          w_step_edge;
    logic          w_timeout;
    logic          w_load;
    logic          w_report;

    qic117_step_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
        .clk       (clk),
        .reset_n   (reset_n),
        .step_n    (step_n),
        .step_edge (w_step_edge)
    );

    assign w_timeout = r_timer == TW'(TIMEOUT_CYCLES - 1);

    // next state: an edge always beats the timeout; enable low aborts from anywhere
    always_comb begin
        w_state_d = r_state;
        w_count_d = r_count;
        w_timer_d = r_timer;
        w_load    = 1'b0;
        if (!enable) begin
            w_state_d = IDLE;
            w_count_d = '0;
            w_timer_d = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_step_edge) begin
                        w_state_d = COUNTING;
                        w_count_d = 6'd1;
                        w_timer_d = '0;
                    end
                end
                COUNTING: begin
                    if (w_step_edge) begin
                        w_count_d = (r_count == 6'd63) ? r_count : r_count + 1'b1;
                        w_timer_d = '0;
                    end else if (w_timeout) begin
                        w_state_d = REPORT;
                        w_load    = 1'b1;
                    end else begin
                        w_timer_d = r_timer + 1'b1;
                    end
                end
                REPORT: begin
                    w_state_d = IDLE;
                    w_count_d = '0;
                    w_timer_d = '0;
                end
                default: w_state_d = IDLE;
            endcase
        end
    end

    // state, counters, latched result and edge strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_timer       <= '0;
            r_pulse_count <= '0;
            r_step_seen   <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_count       <= w_count_d;
            r_timer       <= w_timer_d;
            r_pulse_count <= w_load ? r_count : r_pulse_count;
            r_step_seen   <= w_step_edge && enable;
        end
    end

    assign w_report      = (r_state == REPORT) && enable;
    assign pulse_count   = r_pulse_count;
    assign command_valid = w_report && (r_pulse_count != 6'd0) && (r_pulse_count <= 6'(QIC_MAX_CMD));
    assign cmd_overflow  = w_report && (r_pulse_count > 6'(QIC_MAX_CMD));
    assign busy          = r_state != IDLE;
    assign step_seen     = r_step_seen;
endmodule

// File: tb/tb_qic117_step_counter.sv
// tb_qic117_step_counter: directed STEP scenarios checked against a cycle-stamp command model
`timescale 1ns/1ps
module tb_qic117_step_counter;
    localparam int T = 100;
    localparam int F = 4;
`ifdef QIC117_STEP_GLITCH_FILTER_EN
    localparam int FE = F;
`else
    localparam int FE = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       step_n = 1'b1;
    logic       enable = 1'b1;
    logic [5:0] pulse_count;
    logic       command_valid;
    logic       cmd_overflow;
    logic       busy;
    logic       step_seen;

    int tests = 0;
    int fails = 0;
    int n_strobes = 0;
    int n_seen = 0;
    int base_strobes = 0;

    qic117_step_counter #(.TIMEOUT_CYCLES(T), .FILTER_CYCLES(F)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .step_n        (step_n),
        .enable        (enable),
        .pulse_count   (pulse_count),
        .command_valid (command_valid),
        .cmd_overflow  (cmd_overflow),
        .busy          (busy),
        .step_seen     (step_seen)
    );

    always #5 clk = ~clk;

    // model: a STEP is accepted once the last FE synchronized samples (pin delayed 2 clocks) are low
    // after having been all high; a command ends T clocks after its last accepted edge
    int cyc = 0;
    int last = 0;
    int cnt = 0;
    int m_pc = 0;
    bit m_active = 0, m_rep = 0, m_seen = 0, pa = 1, pb = 1, armed = 1;
    bit hs [FE];

    initial foreach (hs[i]) hs[i] = 1'b1;

    always @(posedge clk or negedge reset_n) begin
        bit e, all0, all1;
        if (!reset_n) begin
            pa = 1; pb = 1; armed = 1;
            foreach (hs[i]) hs[i] = 1'b1;
            m_active = 0; m_rep = 0; m_seen = 0; cnt = 0; m_pc = 0;
        end else begin
            cyc++;
            for (int i = FE - 1; i > 0; i--) hs[i] = hs[i-1];
            hs[0] = pb; pb = pa; pa = step_n;
            all0 = 1; all1 = 1;
            foreach (hs[i]) if (hs[i]) all0 = 0; else all1 = 0;
            e = armed && all0;
            if (all0) armed = 0;
            if (all1) armed = 1;
            m_seen = e && enable;
            if (!enable) begin
                m_active = 0; m_rep = 0; cnt = 0;
            end else if (m_rep) begin
                m_rep = 0;
            end else if (!m_active) begin
                if (e) begin m_active = 1; cnt = 1; last = cyc; end
            end else if (e) begin
                cnt = (cnt < 63) ? cnt + 1 : 63; last = cyc;
            end else if (cyc - last == T) begin
                m_active = 0; m_rep = 1; m_pc = cnt;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        chk("m_pulse_count", pulse_count, m_pc);
        chk("m_command_valid", command_valid, m_rep && enable && m_pc <= 48);
        chk("m_cmd_overflow", cmd_overflow, m_rep && enable && m_pc > 48);
        chk("m_busy", busy, m_active || m_rep);
        chk("m_step_seen", step_seen, m_seen);
        if (command_valid || cmd_overflow) n_strobes++;
        if (step_seen) n_seen++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_train(input int n, input int period);
        repeat (n) begin
            step_n = 1'b0;
            repeat (4) tick();
            step_n = 1'b1;
            repeat (period - 4) tick();
        end
    endtask

    task automatic wait_strobe(input string name, input bit exp_ov, input int exp_pc);
        int k = 0;
        do begin @(negedge clk); k++; end
        while (!(command_valid || cmd_overflow) && k < 3 * T);
        chk({name, "_strobe"}, command_valid || cmd_overflow, 1);
        chk({name, "_ovf"}, cmd_overflow, exp_ov);
        chk({name, "_valid"}, command_valid, !exp_ov);
        chk({name, "_count"}, pulse_count, exp_pc);
        @(negedge clk);
        chk({name, "_busy_after"}, busy, 0);
        chk({name, "_valid_after"}, command_valid || cmd_overflow, 0);
        tick();
        chk({name, "_nstrobes"}, n_strobes - base_strobes, 1);
        base_strobes = n_strobes;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_count", pulse_count, 0);
        chk("rst_strobes", {command_valid, cmd_overflow, step_seen}, 0);
        reset_n = 1'b1;
        repeat (3) tick();

        pulse_train(8, 10);
        wait_strobe("eight", 0, 8);

        pulse_train(50, 10);
        wait_strobe("fifty", 1, 50);

        pulse_train(70, 10);
        wait_strobe("seventy", 1, 63);

        pulse_train(2, 100);
        wait_strobe("late_edge", 0, 2);

        pulse_train(5, 10);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        pulse_train(3, 10);
        wait_strobe("abort", 0, 3);

        pulse_train(4, 10);
        reset_n = 1'b0;
        repeat (3) tick();
        chk("midrst_count", pulse_count, 0);
        chk("midrst_busy", busy, 0);
        reset_n = 1'b1;
        base_strobes = n_strobes;
        repeat (2) tick();
        pulse_train(2, 10);
        wait_strobe("after_reset", 0, 2);

`ifdef QIC117_STEP_GLITCH_FILTER_EN
        begin
            int s0;
            s0 = n_seen;
            step_n = 1'b0;
            repeat (2) tick();
            step_n = 1'b1;
            repeat (20) tick();
            chk("glitch_seen", n_seen - s0, 0);
            step_n = 1'b0;
            repeat (6) tick();
            step_n = 1'b1;
            repeat (20) tick();
            chk("long_seen", n_seen - s0, 1);
            wait_strobe("filtered", 0, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
